gbe_rx_parser: RTL



---
 rtl/gbe_rx_parser.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gbe_rx_parser.sv
// gbe_rx_parser: parses received Ethernet/IPv4/UDP frames, streams matching UDP payload to the app and other frames to the CPU buffer
module gbe_rx_parser (
  input  logic        mac_clk,
  input  logic        mac_rst,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_dvld,
  input  logic        mac_rx_goodframe,
  input  logic        mac_rx_badframe,
  input  logic        local_enable,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic [7:0]  app_data,
  output logic        app_dvld,
  output logic        app_eof,
  output logic        app_err,
  output logic [31:0] app_srcip,
  output logic [15:0] app_srcport,
  output logic [10:0] cpu_rx_buffer_addr,
  output logic [7:0]  cpu_rx_buffer_wr_data,
  output logic        cpu_rx_buffer_we,
  output logic [10:0] cpu_rx_size,
  output logic        cpu_rx_ready,
  input  logic        cpu_rx_ack
);
  typedef enum logic [1:0] {RX_SKIP, RX_IDLE, RX_HDR, RX_APP} rx_state_t;
  rx_state_t state, state_nxt;
  logic [7:0] hdr [0:39];
  logic [10:0] cnt, idx;
  logic [15:0] rem, udp_len;
  logic [47:0] dmac;
  logic [7:0] hold;
  logic ovf, cpu_wr, app_hit, hold_v;
  logic start, fin, last_hdr, counted, mac_match, app_match, publish;
  assign start = state == RX_IDLE && mac_rx_dvld;
  assign idx = start ? 11'd0 : cnt;
  assign fin = mac_rx_goodframe || mac_rx_badframe;
  assign last_hdr = state == RX_HDR && mac_rx_dvld && idx == 11'd41;
  assign counted = state == RX_APP && mac_rx_dvld;
  assign udp_len = {hdr[38], hdr[39]};
  assign dmac = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
  assign mac_match = dmac == local_mac || dmac == 48'hffff_ffff_ffff;
  assign app_match = mac_match && local_enable && {hdr[12], hdr[13]} == 16'h0800 && hdr[14] == 8'h45
    && hdr[23] == 8'h11 && hdr[20][5:0] == 6'd0 && hdr[21] == 8'd0
    && {hdr[30], hdr[31], hdr[32], hdr[33]} == local_ip && {hdr[36], hdr[37]} == local_port;
  assign publish = mac_rx_goodframe && cpu_wr && mac_match && !app_hit && !ovf && cnt >= 11'd14;
  // next state: end pulses always resync to idle; header decision taken on byte 41
  always_comb begin
    state_nxt = state;
    if (fin) state_nxt = RX_IDLE;
    else if (state == RX_SKIP) state_nxt = mac_rx_dvld ? RX_SKIP : RX_IDLE;
    else if (state == RX_IDLE) state_nxt = mac_rx_dvld ? RX_HDR : RX_IDLE;
    else if (last_hdr) state_nxt = app_match && udp_len > 16'd8 ? RX_APP : RX_SKIP;
    else if (counted && rem == 16'd1) state_nxt = RX_SKIP;
  end
  // state register
  always_ff @(posedge mac_clk) state <= mac_rst ? RX_SKIP : state_nxt;
  // header capture by byte index; later bytes never overwrite the fields
  always_ff @(posedge mac_clk) if (mac_rx_dvld && idx < 11'd40) hdr[idx[5:0]] <= mac_rx_data;
  // frame bookkeeping, CPU buffer writes and publish, app hold stage
  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      cpu_wr <= 1'b0;
      app_hit <= 1'b0;
      hold_v <= 1'b0;
      hold <= '0;
      rem <= '0;
      app_data <= '0;
      app_dvld <= 1'b0;
      app_eof <= 1'b0;
      app_err <= 1'b0;
      app_srcip <= '0;
      app_srcport <= '0;
      cpu_rx_buffer_addr <= '0;
      cpu_rx_buffer_wr_data <= '0;
      cpu_rx_buffer_we <= 1'b0;
      cpu_rx_size <= '0;
      cpu_rx_ready <= 1'b0;
    end else begin
      app_dvld <= 1'b0;
      app_eof <= 1'b0;
      app_err <= 1'b0;
      cpu_rx_buffer_we <= mac_rx_dvld && (start ? !cpu_rx_ready : cpu_wr);
      cpu_rx_buffer_addr <= idx;
      cpu_rx_buffer_wr_data <= mac_rx_data;
      if (mac_rx_dvld) begin
        cnt <= idx == 11'h7ff ? idx : idx + 11'd1;
        ovf <= (ovf && !start) || idx == 11'h7ff;
      end
      if (start) cpu_wr <= !cpu_rx_ready;
      else if (fin) cpu_wr <= 1'b0;
      if (start) app_hit <= 1'b0;
      else if (last_hdr) app_hit <= app_match;
      if (last_hdr && app_match) begin
        app_srcip <= {hdr[26], hdr[27], hdr[28], hdr[29]};
        app_srcport <= {hdr[34], hdr[35]};
      end
      if (last_hdr) rem <= udp_len - 16'd8;
      else if (counted) rem <= rem - 16'd1;
      if (counted) begin
        hold <= mac_rx_data;
        hold_v <= 1'b1;
        app_dvld <= hold_v;
        app_data <= hold;
      end else if (fin && hold_v) begin
        hold_v <= 1'b0;
        app_dvld <= 1'b1;
        app_data <= hold;
        app_eof <= 1'b1;
        app_err <= mac_rx_badframe || rem != 16'd0;
      end else if (start) hold_v <= 1'b0;
      if (cpu_rx_ready && cpu_rx_ack) cpu_rx_ready <= 1'b0;
      else if (publish) begin
        cpu_rx_ready <= 1'b1;
        cpu_rx_size <= cnt;
      end
    end
  end
endmodule
